// File: rtl/full_sub_3bit_pkg.sv
// full_sub_3bit_pkg: shared width constant and vector type
// for the registered 3-bit subtractor.
package full_sub_3bit_pkg;

  localparam int SUB_W = 3;

  typedef logic [SUB_W-1:0] sub_vec_t;

endpackage

// File: rtl/full_sub_1bit.sv
// full_sub_1bit: one-bit full-subtractor cell.
// Ports: a - b - bin -> d, borrow-out bout.
module full_sub_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // borrow when b exceeds a, or they match and a borrow ripples in
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_sub_3bit.sv
// full_sub_3bit: registered 3-bit ripple subtractor, D = A - B - bin mod 8.
// Ports: A0..A2, B0..B2, bin, in_valid in; D0..D2, bout, out_valid registered.
module full_sub_3bit
  import full_sub_3bit_pkg::*;
(
  output logic D0,
  output logic D1,
  output logic D2,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic clk,
  input  logic rst,
  input  logic bin,
  input  logic in_valid,
  output logic bout,
  output logic out_valid
);

  sub_vec_t         a_v;
  sub_vec_t         b_v;
  sub_vec_t         d_c;
  logic [SUB_W:0]   brw;

  sub_vec_t         d_q;
  logic             bout_q;
  logic             vld_q;

  assign a_v    = {A2, A1, A0};
  assign b_v    = {B2, B1, B0};
  assign brw[0] = bin;

  for (genvar i = 0; i < SUB_W; i++) begin : g_cell
    full_sub_1bit u_cell (
      .a    (a_v[i]),
      .b    (b_v[i]),
      .bin  (brw[i]),
      .d    (d_c[i]),
      .bout (brw[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      bout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        d_q    <= d_c;
        bout_q <= brw[SUB_W];
      end
    end
  end

  assign D0        = d_q[0];
  assign D1        = d_q[1];
  assign D2        = d_q[2];
  assign bout      = bout_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_sub_3bit.sv
// tb_full_sub_3bit: scoreboard bench for full_sub_3bit
// against an integer-arithmetic reference.
module tb_full_sub_3bit;

  logic clk = 1'b0;
  logic rst;
  logic A0, A1, A2, B0, B1, B2;
  logic bin, in_valid;
  logic D0, D1, D2, bout, out_valid;

  typedef struct {
    logic       v;
    logic [2:0] d;
    logic       b;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [2:0] held_d = 3'd0;
  logic       held_b = 1'b0;

  always #5 clk = ~clk;

  full_sub_3bit dut (
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .A0        (A0),
    .A1        (A1),
    .A2        (A2),
    .B0        (B0),
    .B1        (B1),
    .B2        (B2),
    .clk       (clk),
    .rst       (rst),
    .bin       (bin),
    .in_valid  (in_valid),
    .bout      (bout),
    .out_valid (out_valid)
  );

  task automatic set_ops(input logic [2:0] a, input logic [2:0] b);
    {A2, A1, A0} = a;
    {B2, B1, B0} = b;
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b,
                       input logic bi, input logic v);
    exp_t e;
    int diff;
    @(negedge clk);
    rst = 1'b0;
    set_ops(a, b);
    bin = bi;
    in_valid = v;
    diff = int'(a) - int'(b) - int'(bi);
    e.v = v;
    e.d = 3'((diff + 16) % 8);
    e.b = (diff < 0);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_ops(3'($urandom), 3'($urandom));
    bin = 1'($urandom);
    in_valid = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      checks++;
      held_d = 3'd0;
      held_b = 1'b0;
      if ({out_valid, D2, D1, D0, bout} !== 5'b0) begin
        errors++;
        $display("FAIL reset: got v=%b d=%b bout=%b want v=0 d=000 bout=0",
                 out_valid, {D2, D1, D0}, bout);
      end
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL underrun: output with no expected entry v=%b", out_valid);
    end else begin
      e = sb.pop_front();
      if (e.v) begin
        held_d = e.d;
        held_b = e.b;
      end
      checks++;
      if (out_valid !== e.v || {D2, D1, D0} !== held_d || bout !== held_b) begin
        errors++;
        $display("FAIL result: got v=%b d=%b bout=%b want v=%b d=%b bout=%b",
                 out_valid, {D2, D1, D0}, bout, e.v, held_d, held_b);
      end
    end
  end

  initial begin
    rst = 1'b1;
    set_ops(3'($urandom), 3'($urandom));
    bin = 1'($urandom);
    in_valid = 1'b1;
    do_reset();

    drive(3'b000, 3'b000, 1'b0, 1'b1);
    drive(3'b110, 3'b000, 1'b0, 1'b1);
    drive(3'b000, 3'b100, 1'b0, 1'b1);
    drive(3'b101, 3'b111, 1'b0, 1'b1);
    drive(3'b000, 3'b110, 1'b0, 1'b1);
    drive(3'b100, 3'b011, 1'b0, 1'b1);
    drive(3'b111, 3'b100, 1'b0, 1'b1);
    drive(3'b011, 3'b011, 1'b0, 1'b1);
    drive(3'b000, 3'b000, 1'b1, 1'b1);
    drive(3'b101, 3'b010, 1'b1, 1'b1);

    drive(3'b111, 3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      drive(3'($urandom), 3'($urandom), 1'($urandom), 1'b0);

    for (int i = 0; i < 128; i++)
      drive(3'(i >> 4), 3'(i >> 1), 1'(i), 1'b1);

    for (int i = 0; i < 40; i++)
      drive(3'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));

    drive(3'b010, 3'b101, 1'b0, 1'b1);
    do_reset();
    drive(3'($urandom), 3'($urandom), 1'b0, 1'b0);
    drive(3'b110, 3'b011, 1'b1, 1'b1);

    for (int i = 0; i < 30; i++)
      drive(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));

    drive(3'b000, 3'b000, 1'b0, 1'b0);
    drive(3'b000, 3'b000, 1'b0, 1'b0);
    @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
